ps2_kbd_tx: RTL

PS/2 device-side transmitter: the keyboard end of the PS/2 link whose host-side decoder feeds the system's `ps2_kbd_code`/`strobe`/`err` inputs. It accepts scan-code bytes from a testbench or stimulus block, buffers them in a small FIFO, and serialises each one onto PS/2 clock and data lines as an 11-bit frame. It sits in the simulation top in front of the `PS2CLKA`/`PS2DATA` keyboard pins, so the full host decoder path gets exercised.

---
 rtl/ps2_kbd_tx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: FIFO-buffered scan codes serialised as 11-bit frames.
// Optional macro PS2_TX_ERR_INJECT_EN adds err_i and a per-byte parity-corruption flag.
module ps2_kbd_tx #(
   parameter int CLK_DIV = 4,
   parameter int DEPTH   = 8
) (
   input  logic       clk,
   input  logic       reset_n_i,
   input  logic [7:0] code_i,
   input  logic       strobe_i,
`ifdef PS2_TX_ERR_INJECT_EN
   input  logic       err_i,
`endif
   input  logic       host_inhibit_i,
   output logic       full_o,
   output logic       overflow_o,
   output logic       busy_o,
   output logic       ps2_clk_o,
   output logic       ps2_data_o
);

   // state | meaning
   // IDLE  | lines high, waiting for data and no inhibit
   // HI    | ps2 clock high, data shows current frame bit
   // LO    | ps2 clock low, data held; advance bit or finish
   // GAP   | lines high, busy, inter-frame spacing
   typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_GAP} state_t;

   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(4 * CLK_DIV);
`ifdef PS2_TX_ERR_INJECT_EN
   localparam int W = 9;
`else
   localparam int W = 8;
`endif
   localparam logic [PW-1:0] HALF_M1   = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] GAP_M1    = PW'(4 * CLK_DIV - 1);
   localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
   localparam logic [3:0]    LAST_BIT  = 4'd10;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  wdata;
   logic [W-1:0]  head;
   logic          head_par;
   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic          push, pop, full_now, empty;

   state_t        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [3:0]    bit_q, bit_d;
   logic [10:0]   frame_q, frame_d;

   logic          full_q, full_d, overflow_q, overflow_d, busy_q, busy_d;
   logic          ps2_clk_q, ps2_clk_d, ps2_data_q, ps2_data_d;

`ifdef PS2_TX_ERR_INJECT_EN
   assign wdata    = {err_i, code_i};
   assign head_par = ~(^head[7:0]) ^ head[8];
`else
   assign wdata    = code_i;
   assign head_par = ~(^head[7:0]);
`endif
   assign head = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      full_now   = (wr_ptr_q - rd_ptr_q) == DEPTH_CNT;
      empty      = (wr_ptr_q == rd_ptr_q);
      push       = strobe_i && (!full_now || pop);
      overflow_d = strobe_i && !push;
      wr_ptr_d   = wr_ptr_q + (AW + 1)'(push);
      rd_ptr_d   = rd_ptr_q + (AW + 1)'(pop);
      full_d     = (wr_ptr_d - rd_ptr_d) == DEPTH_CNT;
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty && !host_inhibit_i) begin
               frame_d = {1'b1, head_par, head[7:0], 1'b0};
               bit_d   = 4'd0;
               phase_d = HALF_M1;
               state_d = S_HI;
            end
         end
         S_HI: begin
            if (host_inhibit_i) begin
               phase_d = GAP_M1;
               state_d = S_GAP;
            end else if (phase_q == '0) begin
               phase_d = HALF_M1;
               state_d = S_LO;
            end else begin
               phase_d = phase_q - 1'b1;
            end
         end
         S_LO: begin
            if (host_inhibit_i) begin
               phase_d = GAP_M1;
               state_d = S_GAP;
            end else if (phase_q == '0) begin
               if (bit_q == LAST_BIT) begin
                  pop     = 1'b1;
                  phase_d = GAP_M1;
                  state_d = S_GAP;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  phase_d = HALF_M1;
                  state_d = S_HI;
               end
            end else begin
               phase_d = phase_q - 1'b1;
            end
         end
         default: begin
            if (phase_q == '0) state_d = S_IDLE;
            else               phase_d = phase_q - 1'b1;
         end
      endcase
   end

   // Outputs are derived from the next state so they change together with it.
   always_comb begin
      ps2_clk_d  = (state_d != S_LO);
      ps2_data_d = (state_d == S_HI || state_d == S_LO) ? frame_d[bit_d] : 1'b1;
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         state_q    <= S_IDLE;
         phase_q    <= '0;
         bit_q      <= '0;
         frame_q    <= '1;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         ps2_clk_q  <= 1'b1;
         ps2_data_q <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         state_q    <= state_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         frame_q    <= frame_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         ps2_clk_q  <= ps2_clk_d;
         ps2_data_q <= ps2_data_d;
      end
   end

   assign full_o     = full_q;
   assign overflow_o = overflow_q;
   assign busy_o     = busy_q;
   assign ps2_clk_o  = ps2_clk_q;
   assign ps2_data_o = ps2_data_q;

endmodule
